// File: rtl/disp_pkg.sv
// disp_pkg: segment, anode and blink-select constants shared by the display scanner
package disp_pkg;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_M2  = 4'b1110;
  localparam logic [3:0] AN_M1  = 4'b1101;
  localparam logic [3:0] AN_H2  = 4'b1011;
  localparam logic [3:0] AN_H1  = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [1:0] BL_NONE  = 2'b00;
  localparam logic [1:0] BL_HOURS = 2'b01;
  localparam logic [1:0] BL_MINS  = 2'b10;
  localparam logic [1:0] BL_BOTH  = 2'b11;
  typedef enum logic [1:0] {SL_M2, SL_M1, SL_H2, SL_H1} slot_t;
  function automatic logic [3:0] an_of(input slot_t s);
    return s == SL_M2 ? AN_M2 : s == SL_M1 ? AN_M1 : s == SL_H2 ? AN_H2 : AN_H1;
  endfunction
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: BCD digit to active-low {g,f,e,d,c,b,a}, dash for values above 9
module bcd_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/time_display_scan.sv
// time_display_scan: multiplexes HH:MM onto a 4-digit common-anode display with field blink and colon
module time_display_scan
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] H1,
  input  logic [3:0] H2,
  input  logic [2:0] M1,
  input  logic [3:0] M2,
  input  logic       adjust,
  input  logic [1:0] blink_sel,
  input  logic       sec_pulse,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  logic [RW-1:0] rcnt;
  logic [BW-1:0] bcnt;
  slot_t idx;
  logic [1:0] s_h1, sel_q;
  logic [3:0] s_h2, s_m2, digit, an_n;
  logic [2:0] s_m1;
  logic [6:0] seg_d, seg_n;
  logic valid, bph, col, tc, btc, mask, dp_n;
  assign tc  = rcnt == RW'(REFRESH_DIV - 1);
  assign btc = bcnt == BW'(BLINK_DIV - 1);
  // snapshot only at frame start so a frame never mixes two time values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt  <= '0;
      idx   <= SL_H1;
      valid <= 1'b0;
      s_h1  <= '0;
      s_h2  <= '0;
      s_m1  <= '0;
      s_m2  <= '0;
    end else begin
      rcnt <= tc ? '0 : rcnt + 1'b1;
      if (tc) idx <= slot_t'(idx + 2'd1);
      if (tc && idx == SL_H1) begin
        s_h1  <= H1;
        s_h2  <= H2;
        s_m1  <= M1;
        s_m2  <= M2;
        valid <= 1'b1;
      end
    end
  end
  // a new blink field restarts the phase visible
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt  <= '0;
      bph   <= 1'b0;
      sel_q <= BL_NONE;
      col   <= 1'b1;
    end else begin
      sel_q <= blink_sel;
      bcnt  <= blink_sel != sel_q || btc ? '0 : bcnt + 1'b1;
      bph   <= blink_sel != sel_q ? 1'b0 : btc ? ~bph : bph;
      col   <= adjust ? 1'b1 : sec_pulse ? ~col : col;
    end
  end
  always_comb begin
    digit = idx == SL_M2 ? s_m2 :
            idx == SL_M1 ? (s_m1 > 3'd5 ? 4'hF : {1'b0, s_m1}) :
            idx == SL_H2 ? s_h2 :
                           (s_h1 > 2'd2 ? 4'hF : {2'b00, s_h1});
    mask  = adjust && bph && (idx[1] ? (blink_sel == BL_HOURS || blink_sel == BL_BOTH)
                                     : (blink_sel == BL_MINS  || blink_sel == BL_BOTH));
    an_n  = !valid || mask ? AN_OFF : an_of(idx);
    seg_n = valid ? seg_d : SEG_BLANK;
    dp_n  = !(valid && idx == SL_H2 && col);
  end
  bcd_to_seg7 u_dec (.digit(digit), .seg(seg_d));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_n;
      seg <= seg_n;
      dp  <= dp_n;
    end
  end
endmodule

// File: tb/tb_time_display_scan.sv
// tb_time_display_scan: scoreboard bench; stimulus queues expected lit cycles, monitor checks each one
module tb_time_display_scan;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S9 = 7'b0010000, DASH = 7'b0111111;
  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;
  exp_t sb[$];
  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] h1, blink_sel;
  logic [3:0] h2, m2, an;
  logic [2:0] m1;
  logic [6:0] seg;
  logic adjust, sec_pulse, dp;
  int cyc = 0, checks = 0, errors = 0;
  time_display_scan #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
    .clk(clk), .rst(rst), .H1(h1), .H2(h2), .M1(m1), .M2(m2),
    .adjust(adjust), .blink_sel(blink_sel), .sec_pulse(sec_pulse),
    .an(an), .seg(seg), .dp(dp)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? cyc + 1 : 0;
  always @(negedge clk) begin
    if (rst && an !== 4'b1111) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_lit cyc=%0d got an=%b seg=%b dp=%b expected dark", cyc, an, seg, dp);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc != e.cyc || an !== e.an || seg !== e.seg || dp !== e.dp) begin
          errors++;
          $display("FAIL scan cyc=%0d got an=%b seg=%b dp=%b expected cyc=%0d an=%b seg=%b dp=%b",
                   cyc, an, seg, dp, e.cyc, e.an, e.seg, e.dp);
        end
      end
    end
  end
  task automatic push_slot(input int c0, input logic [3:0] a, input logic [6:0] s, input logic d);
    for (int i = 0; i < 4; i++) sb.push_back('{c0 + i, a, s, d});
  endtask
  task automatic push_frame(input int b, input logic [6:0] s0, s1, s2, s3, input logic d2, input logic [3:0] lit);
    if (lit[0]) push_slot(b,      4'b1110, s0, 1'b1);
    if (lit[1]) push_slot(b + 4,  4'b1101, s1, 1'b1);
    if (lit[2]) push_slot(b + 8,  4'b1011, s2, d2);
    if (lit[3]) push_slot(b + 12, 4'b0111, s3, 1'b1);
  endtask
  task automatic at(input int n);
    while (cyc != n) @(negedge clk);
  endtask
  task automatic check_idle(input string name);
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      errors++;
      $display("FAIL %s got an=%b seg=%b dp=%b expected an=1111 seg=1111111 dp=1", name, an, seg, dp);
    end
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    h1 = 2'd1; h2 = 4'd2; m1 = 3'd3; m2 = 4'd4;
    adjust = 1'b0; blink_sel = 2'b00; sec_pulse = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_hold");
    push_frame(5,  S4, S3, S2, S1, 1'b0, 4'b1111);
    push_frame(21, S4, S3, S2, S1, 1'b0, 4'b1111);
    rst = 1'b1;
    at(25);
    h1 = 2'd2; h2 = 4'd3; m1 = 3'd5; m2 = 4'd9;
    push_frame(37, S9, S5, S3, S2, 1'b1, 4'b1111);
    at(38); sec_pulse = 1'b1;
    at(39); sec_pulse = 1'b0;
    at(41);
    h1 = 2'd3; h2 = 4'd12; m1 = 3'd6; m2 = 4'd0;
    push_frame(53, S0, DASH, DASH, DASH, 1'b1, 4'b1111);
    at(57);
    h1 = 2'd1; h2 = 4'd2; m1 = 3'd3; m2 = 4'd4;
    push_frame(69,  S4, S3, S2, S1, 1'b0, 4'b1111);
    push_frame(85,  S4, S3, S2, S1, 1'b0, 4'b0011);
    push_frame(101, S4, S3, S2, S1, 1'b0, 4'b1111);
    push_frame(117, S4, S3, S2, S1, 1'b0, 4'b0011);
    at(68); adjust = 1'b1; blink_sel = 2'b01;
    at(124); blink_sel = 2'b10;
    push_frame(117, S4, S3, S2, S1, 1'b0, 4'b1100);
    push_frame(133, S4, S3, S2, S1, 1'b0, 4'b1111);
    push_frame(149, S4, S3, S2, S1, 1'b0, 4'b1100);
    push_frame(165, S4, S3, S2, S1, 1'b0, 4'b0011);
    at(130); sec_pulse = 1'b1;
    at(131); sec_pulse = 1'b0;
    at(172);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check_idle("reset_midframe");
    repeat (3) @(negedge clk);
    check_idle("reset_stays_dark");
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
